// File: rtl/vo_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vo_stream_pkg
// Description : Shared types and defaults for the pixel streamer: FSM state
//               encoding, the {pixel,depth} FIFO entry and default frame size.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package vo_stream_pkg;

  localparam logic [11:0] DEFAULT_WIDTH  = 12'd640;
  localparam logic [11:0] DEFAULT_HEIGHT = 12'd480;

  localparam int unsigned PIXEL_W = 8;
  localparam int unsigned DEPTH_W = 10;
  localparam int unsigned ENTRY_W = PIXEL_W + DEPTH_W;

  // One buffered host beat; pixel occupies the upper bits.
  typedef struct packed {
    logic [PIXEL_W-1:0] pixel;
    logic [DEPTH_W-1:0] depth;
  } entry_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_SOF  = 3'd1,
    START     = 3'd2,
    STREAM    = 3'd3,
    DRAIN_END = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pixel_streamer_if.sv
`default_nettype none
// ============================================================================
// Module      : pixel_streamer_if
// Description : Host-side and detector-side signal bundle of the streamer.
// Ports       : master - drives enable, host beat and chip_ready;
//                        observes ready and detector outputs
//               slave  - the streamer view (mirror of master)
// Revision    : 1.0 - initial release
// ============================================================================
interface pixel_streamer_if;
  import vo_stream_pkg::*;

  logic               i_enable;
  logic               i_host_valid;
  logic               o_host_ready;
  logic               i_host_sof;
  logic [PIXEL_W-1:0] i_host_pixel;
  logic [DEPTH_W-1:0] i_host_depth;
  logic               i_chip_ready;
  logic               o_frame_start;
  logic               o_valid;
  logic [PIXEL_W-1:0] o_pixel;
  logic [DEPTH_W-1:0] o_depth;
  logic               o_frame_done;
  logic               o_sync_err;

  modport master (
    output i_enable, i_host_valid, i_host_sof, i_host_pixel, i_host_depth, i_chip_ready,
    input  o_host_ready, o_frame_start, o_valid, o_pixel, o_depth, o_frame_done, o_sync_err
  );

  modport slave (
    input  i_enable, i_host_valid, i_host_sof, i_host_pixel, i_host_depth, i_chip_ready,
    output o_host_ready, o_frame_start, o_valid, o_pixel, o_depth, o_frame_done, o_sync_err
  );

endinterface
`default_nettype wire

// File: rtl/stream_fifo.sv
`default_nettype none
// ============================================================================
// Module      : stream_fifo
// Description : Register-based show-ahead FIFO. rdata always presents the
//               oldest entry; callers must not push when full or pop when empty.
// Ports       : clk, rst_n (async active-low), push/wdata, pop/rdata,
//               full, empty
// Revision    : 1.0 - initial release
// ============================================================================
module stream_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 18
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              push,
  input  wire logic [DATA_W-1:0] wdata,
  input  wire logic              pop,
  output logic      [DATA_W-1:0] rdata,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

endmodule
`default_nettype wire

// File: rtl/pixel_streamer.sv
`default_nettype none
// ============================================================================
// Module      : pixel_streamer
// Description : Captures one host frame (WIDTH*HEIGHT beats starting at a
//               start-of-frame beat) through an elastic FIFO and replays it to
//               the detector with frame_start / frame_done framing pulses.
// Ports       : i_clk, i_rst_n (async active-low)
//               bus (slave) - host beat handshake, enable, chip_ready and
//                             detector outputs
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_streamer
  import vo_stream_pkg::*;
#(
  parameter logic [11:0] WIDTH      = DEFAULT_WIDTH,
  parameter logic [11:0] HEIGHT     = DEFAULT_HEIGHT,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input wire logic         i_clk,
  input wire logic         i_rst_n,
  pixel_streamer_if.slave  bus
);

  localparam logic [23:0] FRAME_BEATS = {12'd0, WIDTH} * {12'd0, HEIGHT};

  state_t      state;
  state_t      state_next;
  logic        host_ready;
  logic        host_fire;
  logic        frame_start;
  logic        frame_done;
  logic        sync_err;
  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  entry_t      wr_entry;
  entry_t      rd_entry;
  logic        valid;
  logic [7:0]  pixel;
  logic [9:0]  depth;
  logic [23:0] wr_count;
  logic [11:0] x;
  logic [11:0] y;
  logic        last_beat;

  assign wr_entry  = '{pixel: bus.i_host_pixel, depth: bus.i_host_depth};
  assign last_beat = valid && (x == WIDTH - 12'd1) && (y == HEIGHT - 12'd1);

  stream_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (ENTRY_W)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (rd_entry),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (bus.i_enable) state_next = WAIT_SOF;
      WAIT_SOF:  if (host_fire && bus.i_host_sof) state_next = START;
      START:     state_next = STREAM;
      STREAM:    if (last_beat) state_next = DRAIN_END;
      DRAIN_END: state_next = bus.i_enable ? WAIT_SOF : IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Output / control logic
  always_comb begin
    host_ready  = 1'b0;
    host_fire   = 1'b0;
    frame_start = (state == START);
    frame_done  = (state == DRAIN_END);
    sync_err    = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    if ((state == WAIT_SOF) || (state == START) || (state == STREAM)) begin
      host_ready = !fifo_full && (wr_count < FRAME_BEATS);
    end
    host_fire = bus.i_host_valid && host_ready;
    // A non-sof beat while hunting for sof is swallowed, not buffered.
    sync_err  = host_fire && (((state == WAIT_SOF) && !bus.i_host_sof) ||
                              ((state == STREAM) && bus.i_host_sof));
    push      = host_fire && !((state == WAIT_SOF) && !bus.i_host_sof);
    // Popping already in START gives the 2-cycle first-pixel latency while
    // keeping o_valid low during the START cycle itself.
    pop       = ((state == START) || (state == STREAM)) && !fifo_empty && bus.i_chip_ready;
  end

  // Registered detector outputs; pixel/depth hold while valid is low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid <= 1'b0;
      pixel <= '0;
      depth <= '0;
    end else begin
      valid <= pop;
      if (pop) begin
        pixel <= rd_entry.pixel;
        depth <= rd_entry.depth;
      end
    end
  end

  // Input beat count bounds the frame; output x/y locate the frame end.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_count <= '0;
      x        <= '0;
      y        <= '0;
    end else begin
      if ((state == IDLE) || (state == DRAIN_END)) wr_count <= '0;
      else if (push)                               wr_count <= wr_count + 24'd1;
      if (valid) begin
        if (x == WIDTH - 12'd1) begin
          x <= '0;
          y <= (y == HEIGHT - 12'd1) ? 12'd0 : y + 12'd1;
        end else begin
          x <= x + 12'd1;
        end
      end
    end
  end

  assign bus.o_host_ready  = host_ready;
  assign bus.o_frame_start = frame_start;
  assign bus.o_frame_done  = frame_done;
  assign bus.o_sync_err    = sync_err;
  assign bus.o_valid       = valid;
  assign bus.o_pixel       = pixel;
  assign bus.o_depth       = depth;

endmodule
`default_nettype wire

// File: tb/tb_pixel_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_streamer
// Description : Self-checking bench for pixel_streamer (4x2 frame, 4-deep
//               FIFO). A monitor records every output beat and pulse; a
//               frame-level model derives the expected output stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_streamer;
  import vo_stream_pkg::*;

  localparam logic [11:0] W       = 12'd4;
  localparam logic [11:0] H       = 12'd2;
  localparam int          FRAME   = 8;
  localparam int          TIMEOUT = 300;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pixel_streamer_if bus();

  pixel_streamer #(
    .WIDTH      (W),
    .HEIGHT     (H),
    .FIFO_DEPTH (4)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  logic [17:0] got_q[$];
  int          got_cyc[$];
  int          acc_cnt   = 0;
  int          start_cnt = 0;
  int          done_cnt  = 0;
  int          err_cnt   = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.i_host_valid && bus.o_host_ready) acc_cnt++;
      if (bus.o_valid) begin
        got_q.push_back({bus.o_pixel, bus.o_depth});
        got_cyc.push_back(cyc);
      end
      if (bus.o_frame_start) start_cnt++;
      if (bus.o_frame_done)  done_cnt++;
      if (bus.o_sync_err)    err_cnt++;
    end
  end

  // Stimulus and reference model
  logic        st_sof[$];
  logic [7:0]  st_pix[$];
  logic [9:0]  st_dep[$];
  int          st_gap[$];
  logic [17:0] exp_q[$];
  int          exp_sync;
  int          exp_frames;
  int          first_hs_cyc;

  task automatic clear_stim();
    st_sof.delete(); st_pix.delete(); st_dep.delete(); st_gap.delete();
  endtask

  task automatic add_beat(input logic sof, input logic [7:0] pix, input int gap);
    st_sof.push_back(sof);
    st_pix.push_back(pix);
    st_dep.push_back(10'($urandom_range(0, 1023)));
    st_gap.push_back(gap);
  endtask

  // Frame rules: beats before a sof are dropped with an error; a frame is
  // FRAME beats from its sof; a sof inside a frame is an error but still data.
  task automatic run_model();
    bit waiting = 1'b1;
    int n = 0;
    exp_q.delete();
    exp_sync   = 0;
    exp_frames = 0;
    foreach (st_sof[i]) begin
      if (waiting) begin
        if (!st_sof[i]) exp_sync++;
        else begin
          waiting = 1'b0;
          n = 1;
          exp_q.push_back({st_pix[i], st_dep[i]});
        end
      end else begin
        if (st_sof[i]) exp_sync++;
        exp_q.push_back({st_pix[i], st_dep[i]});
        n++;
      end
      if (!waiting && n == FRAME) begin
        waiting = 1'b1;
        exp_frames++;
      end
    end
  endtask

  task automatic drive_stim();
    foreach (st_sof[i]) begin
      int waited = 0;
      if (st_gap[i] > 0) begin
        bus.i_host_valid = 1'b0;
        repeat (st_gap[i]) @(posedge clk);
        #1;
      end
      bus.i_host_valid = 1'b1;
      bus.i_host_sof   = st_sof[i];
      bus.i_host_pixel = st_pix[i];
      bus.i_host_depth = st_dep[i];
      @(negedge clk);
      while (!bus.o_host_ready && waited < TIMEOUT) begin
        @(negedge clk);
        waited++;
      end
      checks++;
      if (!bus.o_host_ready) begin
        errors++;
        $display("FAIL host_handshake beat %0d: ready=%0b after %0d cycles, required 1",
                 i, bus.o_host_ready, waited);
        bus.i_host_valid = 1'b0;
        return;
      end
      if (i == 0) first_hs_cyc = cyc;
      @(posedge clk);
      #1;
    end
    bus.i_host_valid = 1'b0;
    bus.i_host_sof   = 1'b0;
  endtask

  task automatic arm();
    bus.i_enable = 1'b1;
    @(posedge clk);
    #1;
    bus.i_enable = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int t = 0;
    while (done_cnt < target && t < TIMEOUT) begin
      @(negedge clk);
      #1;
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Tests
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.o_host_ready, bus.o_frame_start, bus.o_valid, bus.o_frame_done,
         bus.o_sync_err, bus.o_pixel, bus.o_depth} !== 23'd0) begin
      errors++;
      $display("FAIL reset_in: outputs=%h, required 0", {bus.o_host_ready, bus.o_frame_start,
               bus.o_valid, bus.o_frame_done, bus.o_sync_err, bus.o_pixel, bus.o_depth});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.o_host_ready, bus.o_frame_start, bus.o_valid, bus.o_frame_done,
         bus.o_sync_err, bus.o_pixel, bus.o_depth} !== 23'd0) begin
      errors++;
      $display("FAIL reset_idle: outputs=%h, required 0", {bus.o_host_ready, bus.o_frame_start,
               bus.o_valid, bus.o_frame_done, bus.o_sync_err, bus.o_pixel, bus.o_depth});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_frame();
    int b0 = got_q.size();
    int d0 = done_cnt;
    int s0 = start_cnt;
    int e0 = err_cnt;
    bit run_ok = 1'b1;
    clear_stim();
    for (int i = 0; i < FRAME; i++) add_beat(i == 0, 8'(i), 0);
    run_model();
    arm();
    drive_stim();
    wait_frames(d0 + 1);
    checks++;
    if (start_cnt - s0 !== 1) begin errors++; $display("FAIL basic_start: got %0d, required 1", start_cnt - s0); end
    checks++;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL basic_done: got %0d, required 1", done_cnt - d0); end
    checks++;
    if (err_cnt - e0 !== exp_sync) begin errors++; $display("FAIL basic_sync: got %0d, required %0d", err_cnt - e0, exp_sync); end
    checks++;
    if (got_q.size() - b0 !== exp_q.size()) begin
      errors++; $display("FAIL basic_count: got %0d beats, required %0d", got_q.size() - b0, exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (b0 + k >= got_q.size()) begin errors++; $display("FAIL basic_beat%0d: missing, required %h", k, exp_q[k]); end
      else if (got_q[b0 + k] !== exp_q[k]) begin
        errors++; $display("FAIL basic_beat%0d: got %h, required %h", k, got_q[b0 + k], exp_q[k]);
      end
    end
    if (got_q.size() - b0 >= FRAME) begin
      for (int k = 1; k < FRAME; k++)
        if (got_cyc[b0 + k] != got_cyc[b0 + k - 1] + 1) run_ok = 1'b0;
      checks++;
      if (!run_ok) begin errors++; $display("FAIL basic_back_to_back: valid run broken, required 8 consecutive"); end
      checks++;
      if (got_cyc[b0] - first_hs_cyc !== 2) begin
        errors++; $display("FAIL basic_latency: got %0d cycles, required 2", got_cyc[b0] - first_hs_cyc);
      end
    end
  endtask

  task automatic test_sync_discard();
    int b0 = got_q.size();
    int d0 = done_cnt;
    int e0 = err_cnt;
    bit leaked = 1'b0;
    clear_stim();
    add_beat(1'b0, 8'hA0, 0);
    add_beat(1'b0, 8'hA1, 0);
    for (int i = 0; i < FRAME; i++) add_beat(i == 0, 8'($urandom_range(0, 127)), 0);
    run_model();
    arm();
    drive_stim();
    wait_frames(d0 + 1);
    checks++;
    if (err_cnt - e0 !== exp_sync) begin errors++; $display("FAIL sync_err_count: got %0d, required %0d", err_cnt - e0, exp_sync); end
    checks++;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL sync_done: got %0d, required 1", done_cnt - d0); end
    for (int k = b0; k < got_q.size(); k++)
      if (got_q[k][17:10] == 8'hA0 || got_q[k][17:10] == 8'hA1) leaked = 1'b1;
    checks++;
    if (leaked) begin errors++; $display("FAIL sync_discard: discarded pixel seen=1, required 0"); end
    checks++;
    if (got_q.size() - b0 !== exp_q.size()) begin
      errors++; $display("FAIL sync_count: got %0d beats, required %0d", got_q.size() - b0, exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (b0 + k >= got_q.size()) begin errors++; $display("FAIL sync_beat%0d: missing, required %h", k, exp_q[k]); end
      else if (got_q[b0 + k] !== exp_q[k]) begin
        errors++; $display("FAIL sync_beat%0d: got %h, required %h", k, got_q[b0 + k], exp_q[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    int b0 = got_q.size();
    int a0 = acc_cnt;
    int d0 = done_cnt;
    clear_stim();
    for (int i = 0; i < FRAME; i++) add_beat(i == 0, 8'($urandom_range(0, 255)), 0);
    run_model();
    arm();
    fork
      drive_stim();
      begin
        int t = 0;
        while (got_q.size() < b0 + 2 && t < TIMEOUT) begin
          @(negedge clk);
          #1;
          t++;
        end
        @(posedge clk);
        #1;
        bus.i_chip_ready = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (bus.o_host_ready !== 1'b0) begin
          errors++; $display("FAIL bp_ready_drop: ready=%0b, required 0", bus.o_host_ready);
        end
        checks++;
        if ((acc_cnt - a0) - (got_q.size() - b0) !== 4) begin
          errors++; $display("FAIL bp_buffered: got %0d beats held, required 4",
                             (acc_cnt - a0) - (got_q.size() - b0));
        end
        @(posedge clk);
        #1;
        bus.i_chip_ready = 1'b1;
      end
    join
    wait_frames(d0 + 1);
    checks++;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL bp_done: got %0d, required 1", done_cnt - d0); end
    checks++;
    if (got_q.size() - b0 !== exp_q.size()) begin
      errors++; $display("FAIL bp_count: got %0d beats, required %0d", got_q.size() - b0, exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (b0 + k >= got_q.size()) begin errors++; $display("FAIL bp_beat%0d: missing, required %h", k, exp_q[k]); end
      else if (got_q[b0 + k] !== exp_q[k]) begin
        errors++; $display("FAIL bp_beat%0d: got %h, required %h", k, got_q[b0 + k], exp_q[k]);
      end
    end
  endtask

  task automatic test_sof_midframe();
    int b0 = got_q.size();
    int d0 = done_cnt;
    int e0 = err_cnt;
    clear_stim();
    for (int i = 0; i < FRAME; i++)
      add_beat((i == 0) || (i == 5), 8'($urandom_range(0, 255)), (i == 0) ? 0 : $urandom_range(0, 2));
    run_model();
    arm();
    drive_stim();
    wait_frames(d0 + 1);
    checks++;
    if (err_cnt - e0 !== exp_sync) begin errors++; $display("FAIL midsof_sync: got %0d, required %0d", err_cnt - e0, exp_sync); end
    checks++;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL midsof_done: got %0d, required 1", done_cnt - d0); end
    checks++;
    if (got_q.size() - b0 !== exp_q.size()) begin
      errors++; $display("FAIL midsof_count: got %0d beats, required %0d", got_q.size() - b0, exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (b0 + k >= got_q.size()) begin errors++; $display("FAIL midsof_beat%0d: missing, required %h", k, exp_q[k]); end
      else if (got_q[b0 + k] !== exp_q[k]) begin
        errors++; $display("FAIL midsof_beat%0d: got %h, required %h", k, got_q[b0 + k], exp_q[k]);
      end
    end
  endtask

  task automatic test_two_frames();
    int b0 = got_q.size();
    int d0 = done_cnt;
    int s0 = start_cnt;
    int e0 = err_cnt;
    clear_stim();
    for (int i = 0; i < 2 * FRAME; i++)
      add_beat((i % FRAME) == 0, 8'($urandom_range(0, 255)), $urandom_range(0, 2));
    run_model();
    bus.i_enable = 1'b1;
    @(posedge clk);
    #1;
    fork
      drive_stim();
      begin
        int t = 0;
        while (done_cnt < d0 + 2 && t < 2 * TIMEOUT) begin
          @(posedge clk);
          #1;
          bus.i_chip_ready = ($urandom_range(0, 3) != 0);
          t++;
        end
        bus.i_chip_ready = 1'b1;
        bus.i_enable     = 1'b0;
      end
    join
    wait_frames(d0 + 2);
    checks++;
    if (start_cnt - s0 !== 2) begin errors++; $display("FAIL two_start: got %0d, required 2", start_cnt - s0); end
    checks++;
    if (done_cnt - d0 !== exp_frames) begin errors++; $display("FAIL two_done: got %0d, required %0d", done_cnt - d0, exp_frames); end
    checks++;
    if (err_cnt - e0 !== exp_sync) begin errors++; $display("FAIL two_sync: got %0d, required %0d", err_cnt - e0, exp_sync); end
    checks++;
    if (got_q.size() - b0 !== exp_q.size()) begin
      errors++; $display("FAIL two_count: got %0d beats, required %0d", got_q.size() - b0, exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (b0 + k >= got_q.size()) begin errors++; $display("FAIL two_beat%0d: missing, required %h", k, exp_q[k]); end
      else if (got_q[b0 + k] !== exp_q[k]) begin
        errors++; $display("FAIL two_beat%0d: got %h, required %h", k, got_q[b0 + k], exp_q[k]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int b0;
    int d0;
    int s0;
    clear_stim();
    for (int i = 0; i < 4; i++) add_beat(i == 0, 8'($urandom_range(0, 255)), 0);
    arm();
    drive_stim();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.o_host_ready, bus.o_frame_start, bus.o_valid, bus.o_frame_done,
         bus.o_sync_err, bus.o_pixel, bus.o_depth} !== 23'd0) begin
      errors++;
      $display("FAIL midreset_outputs: outputs=%h, required 0", {bus.o_host_ready, bus.o_frame_start,
               bus.o_valid, bus.o_frame_done, bus.o_sync_err, bus.o_pixel, bus.o_depth});
    end
    d0 = done_cnt;
    b0 = got_q.size();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (done_cnt !== d0 || got_q.size() !== b0) begin
      errors++; $display("FAIL midreset_quiet: done=%0d beats=%0d, required 0 and 0", done_cnt - d0, got_q.size() - b0);
    end
    s0 = start_cnt;
    clear_stim();
    for (int i = 0; i < FRAME; i++) add_beat(i == 0, 8'($urandom_range(0, 255)), $urandom_range(0, 1));
    run_model();
    arm();
    drive_stim();
    wait_frames(d0 + 1);
    checks++;
    if (start_cnt - s0 !== 1 || done_cnt - d0 !== 1) begin
      errors++; $display("FAIL midreset_frame: start=%0d done=%0d, required 1 and 1", start_cnt - s0, done_cnt - d0);
    end
    checks++;
    if (got_q.size() - b0 !== exp_q.size()) begin
      errors++; $display("FAIL midreset_count: got %0d beats, required %0d", got_q.size() - b0, exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (b0 + k >= got_q.size()) begin errors++; $display("FAIL midreset_beat%0d: missing, required %h", k, exp_q[k]); end
      else if (got_q[b0 + k] !== exp_q[k]) begin
        errors++; $display("FAIL midreset_beat%0d: got %h, required %h", k, got_q[b0 + k], exp_q[k]);
      end
    end
  endtask

  initial begin
    bus.i_enable     = 1'b0;
    bus.i_host_valid = 1'b0;
    bus.i_host_sof   = 1'b0;
    bus.i_host_pixel = '0;
    bus.i_host_depth = '0;
    bus.i_chip_ready = 1'b1;
    first_hs_cyc     = 0;
    test_reset();
    test_basic_frame();
    test_sync_discard();
    test_backpressure();
    test_sof_midframe();
    test_two_frames();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/pixel_streamer.md
PIXEL_STREAMER -- requirements
Module: pixel_streamer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 12'd640, meaning pixels per line.
REQ-002 The block SHALL have parameter HEIGHT, default 12'd480, meaning lines per frame.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4 (power of two, >=2), meaning entries in the elastic buffer.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 i_clk  in  1  the single clock.
REQ-006 i_rst_n  in  1  asynchronous active-low reset.
REQ-007 i_enable  in  1  level; arms capture of the next frame.
REQ-008 i_host_valid  in  1  host beat valid.
REQ-009 o_host_ready  out  1  block accepts a host beat this cycle.
REQ-010 i_host_sof  in  1  host beat is the first pixel of a frame.
REQ-011 i_host_pixel  in  8  grey pixel.
REQ-012 i_host_depth  in  10  depth sample.
REQ-013 i_chip_ready  in  1  ready from the detector datapath.
REQ-014 o_frame_start  out  1  one-cycle frame-start pulse to the detector.
REQ-015 o_valid  out  1  o_pixel/o_depth valid.
REQ-016 o_pixel  out  8  pixel to the detector.
REQ-017 o_depth  out  10  depth to the detector.
REQ-018 o_frame_done  out  1  one-cycle pulse after the last pixel of a frame is sent.
REQ-019 o_sync_err  out  1  one-cycle pulse on a framing violation.

Function
REQ-020 The FSM SHALL have states IDLE, WAIT_SOF, START, STREAM, DRAIN_END.
REQ-021 IDLE SHALL go to WAIT_SOF when i_enable=1; o_host_ready=0 in IDLE.
REQ-022 In WAIT_SOF a host handshake with i_host_sof=0 SHALL be consumed and discarded and SHALL pulse o_sync_err.
REQ-023 In WAIT_SOF a handshake with i_host_sof=1 SHALL be written to the FIFO, and the FSM SHALL go to START.
REQ-024 START SHALL last exactly one cycle with o_frame_start=1 and o_valid=0; the FSM then goes to STREAM.
REQ-025 o_host_ready SHALL be 1 only in WAIT_SOF/START/STREAM, only when the FIFO is not full, and only while beats written this frame are fewer than WIDTH*HEIGHT.
REQ-026 In STREAM, o_valid SHALL be registered and SHALL be asserted for a FIFO entry in the cycle after that entry is popped; a pop happens when the FIFO is non-empty and i_chip_ready=1.
REQ-027 Output counters x (0..WIDTH-1) and y (0..HEIGHT-1) SHALL advance per output beat; x wraps to 0 and y increments at x=WIDTH-1.
REQ-028 On the output beat with x=WIDTH-1, y=HEIGHT-1, the FSM SHALL go to DRAIN_END; DRAIN_END SHALL pulse o_frame_done for one cycle and return to IDLE, or to WAIT_SOF if i_enable=1.
REQ-029 A handshake with i_host_sof=1 during STREAM SHALL pulse o_sync_err, and the beat SHALL still be treated as a normal pixel.
REQ-030 A push and a pop in the same cycle SHALL leave the occupancy unchanged; a push to a full FIFO or a pop from an empty FIFO SHALL never occur.
REQ-031 Minimum latency SHALL be 2 cycles from host handshake to o_valid for the first pixel (START cycle), then 1 cycle in steady state; throughput SHALL be 1 pixel/cycle with both sides ready.
REQ-032 o_pixel/o_depth SHALL hold their value while o_valid=0.

Reset
REQ-033 Reset SHALL force state IDLE, FIFO empty, counters 0, and o_frame_start, o_valid, o_frame_done, o_sync_err and o_host_ready to 0, with o_pixel=0 and o_depth=0.
REQ-034 Reset asserted mid-frame SHALL discard buffered pixels, and no o_frame_done SHALL follow.

Structure
REQ-035 The state enum, the {pixel,depth} entry typedef (18 bits) and WIDTH/HEIGHT defaults SHALL live in a shared vo_stream_pkg.
REQ-036 The FIFO SHALL be the sub-module stream_fifo (registers, parameterised depth/width, full/empty flags).

Verification (WIDTH=4, HEIGHT=2, FIFO_DEPTH=4)
REQ-037 Frame of 8 beats, sof on beat 0, chip_ready=1 -> the bench SHALL see one o_frame_start, then 8 consecutive o_valid carrying pixels 0..7, then o_frame_done once.
REQ-038 2 beats with sof=0 before sof -> the bench SHALL see 2 o_sync_err pulses, and neither discarded beat appears on o_pixel.
REQ-039 chip_ready=0 for 10 cycles mid-frame -> o_host_ready SHALL drop after 4 buffered beats, and the pixel order SHALL be preserved with no loss.
REQ-040 sof=1 on beat 5 -> the bench SHALL see o_sync_err once, with 8 pixels still output and o_frame_done once.
REQ-041 i_rst_n low after beat 3 -> all outputs SHALL be 0 next cycle; a new frame SHALL then stream cleanly from x=0, y=0.
REQ-042 i_enable held 1 across two frames -> the bench SHALL see 2 o_frame_start and 2 o_frame_done, with 16 pixels total.
